clint_multihart: RTL
====================

Name: clint_multihart

Overview:
Parametrised core-local interruptor, the successor to the single-hart CLINT. Provides one shared 64-bit mtime counter with a programmable tick prescaler, and per-hart mtimecmp and msip registers for NUM_HARTS harts. Generates per-hart timer and software interrupt lines to each hart's CSR unit. Sits on the 32-bit data bus behind the peripheral address decoder and has a registered one-cycle read path.

Parameters:
NUM_HARTS, 2, number of harts served (1..16); sets irq vector width and register replication.
TICK_DIV, 1, clk_i cycles per mtime increment (1..65535); 1 means increment every cycle.
MTIMECMP_BASE, 16'h4000, offset of hart 0 mtimecmp low word; hart h low at base+8h, high at base+8h+4.
MSIP_BASE, 16'h0000, offset of hart 0 msip; hart h at base+4h.
MTIME_BASE, 16'hBFF8, offset of mtime low word; high word at +4.

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
req_i  in  1  bus access request, single-cycle pulse per access
we_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  `DATA_WIDTH  byte address; only addr_i[15:0] is decoded
data_i  in  `DATA_WIDTH  write data
data_o  out  `DATA_WIDTH  read data, valid while ack_o=1
ack_o  out  1  access completion, one cycle after req_i
timer_irq_o  out  NUM_HARTS  per-hart machine timer interrupt, registered
software_irq_o  out  NUM_HARTS  per-hart machine software interrupt, registered

Behaviour:
- Reset values: mtime=0, prescaler=0, every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, every msip=0, data_o=0, ack_o=0, all irq outputs=0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. mtime increments by 1 in the cycle the prescaler wraps. With TICK_DIV=1, mtime increments every cycle.
- mtime is a single 64-bit register and wraps from 2^64-1 to 0. Carry into the high word is implicit in the 64-bit add.
- mtime keeps counting during bus accesses, including writes to msip or mtimecmp.
- A write to an mtime word replaces that word with data_i and inhibits the increment in that cycle. The other word holds its value with no carry applied. The prescaler is not reset.
- Writes to mtimecmp low/high and msip take effect at the clock edge.
- msip stores only data_i[0]. Reads of msip return {31'b0, msip}.
- Accesses with req_i=1 and an unmapped address: writes are ignored, reads return 0, and ack_o is still asserted.
- Access to a hart index >= NUM_HARTS is treated as unmapped.
- Read latency: data_o and ack_o are registered. For req_i at cycle N, ack_o=1 and data_o are valid at N+1 and return to 0 at N+2 unless a new request arrives.
- Write ack: ack_o=1 at N+1; data_o=0.
- Read data reflects the register state before any same-cycle update. An mtime read returns the pre-increment value.
- Back-to-back req_i every cycle is supported, giving one ack per request.
- timer_irq_o[h] is registered: next value = (mtime >= mtimecmp[h]), a 64-bit unsigned compare on the current register values. There is no special case for mtimecmp=0; reset to all-ones is what keeps the line quiet.
- Because of the registered compare, irq assertion lags the mtime or mtimecmp update by one cycle.
- timer_irq_o is level, not sticky. It deasserts one cycle after software raises mtimecmp above mtime or rewrites mtime below it.
- software_irq_o[h] is the registered copy of msip[h] and lags a write by one cycle.
- Reset mid-operation clears everything to reset values in the next cycle. Any pending ack is dropped.

Decomposition:
- Shared header alongside defines.v holds the offset defaults MSIP_BASE, MTIMECMP_BASE, MTIME_BASE and the per-hart strides 4 and 8, as defines.
- `DATA_WIDTH and `ZERO come from defines.v.
- One sub-module: clint_mtime. It contains the prescaler plus the 64-bit counter, with word write-enables and data inputs and a 64-bit mtime output. The per-hart register arrays and compare logic stay in the top as generate loops.

Test Plan:
- Reset, then idle 10 cycles with TICK_DIV=1 -> mtime reads 10 or 11 depending on read cycle; all irqs 0; mtimecmp hart1 reads 32'hFFFF_FFFF in both words.
- TICK_DIV=4, read mtime after 40 cycles from reset -> mtime=10 (±1 by phase); no change across 3 consecutive cycles between ticks.
- Write mtime low=32'hFFFF_FFFE, high=0, TICK_DIV=1 -> after 2 ticks high=1 and low=0 (carry); write high=32'hFFFF_FFFF, low=32'hFFFF_FFFF -> next tick reads 0/0 (64-bit wrap).
- Hart 1 mtimecmp={0,100}, mtime=0 -> timer_irq_o=2'b10 from the cycle after mtime reaches 100; hart 0 stays 0; write mtimecmp low=1000 -> irq drops one cycle later.
- Write msip hart0=32'h3, hart1=0 -> software_irq_o=2'b01 one cycle later; readback msip0=32'h1; write hart index 2 (addr 0x8) -> ignored, reads 0, ack_o still 1.
- Back-to-back reads of mtime low then mtime high, plus rst_i asserted during a read -> one ack per request; on reset, ack_o, data_o and irqs are 0 the next cycle.

Source files
------------

// File: rtl/clint_multihart_pkg.sv
// Register-select types and the address decoder shared by the CLINT files.
`ifndef CLINT_DEFINES_SV
`include "clint_defines.sv"
`endif

package clint_multihart_pkg;

    localparam int MAX_HARTS = 16;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_MTIME_LO,
        REG_MTIME_HI
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] hart;
    } dec_t;

    // Offsets below a base wrap to >= 2^16 in 17 bits and so fall outside every window.
    function automatic dec_t decode_addr(
        input logic [15:0] off,
        input logic [15:0] msip_base,
        input logic [15:0] cmp_base,
        input logic [15:0] mtime_base,
        input int          num_harts
    );
        dec_t        d;
        logic [16:0] rel_msip;
        logic [16:0] rel_cmp;
        d.sel    = REG_NONE;
        d.hart   = 4'd0;
        rel_msip = {1'b0, off} - {1'b0, msip_base};
        rel_cmp  = {1'b0, off} - {1'b0, cmp_base};
        if (off == mtime_base) begin
            d.sel = REG_MTIME_LO;
        end else if (off == mtime_base + 16'd4) begin
            d.sel = REG_MTIME_HI;
        end else if (rel_cmp < 17'(`MTIMECMP_STRIDE * num_harts)) begin
            if (rel_cmp[1:0] == 2'b00) begin
                d.sel  = rel_cmp[2] ? REG_CMP_HI : REG_CMP_LO;
                d.hart = rel_cmp[6:3];
            end
        end else if (rel_msip < 17'(`MSIP_STRIDE * num_harts) && rel_msip[1:0] == 2'b00) begin
            d.sel  = REG_MSIP;
            d.hart = rel_msip[5:2];
        end
        return d;
    endfunction

endpackage

// File: rtl/clint_defines.sv
// Shared bus width, zero word and CLINT register map defaults.
// Guarded so it can be pulled in by several files of one compilation unit.
`ifndef CLINT_DEFINES_SV
`define CLINT_DEFINES_SV

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

`ifndef ZERO
`define ZERO 32'h0000_0000
`endif

`define MSIP_BASE          16'h0000
`define MTIMECMP_BASE      16'h4000
`define MTIME_BASE         16'hBFF8
`define MSIP_STRIDE        4
`define MTIMECMP_STRIDE    8

`endif

// File: rtl/clint_mtime.sv
// Shared 64-bit mtime counter advanced by a 0..TICK_DIV-1 prescaler.
// Latency: word writes and ticks land at the clock edge; no backpressure.
// A word write wins over the tick in its cycle and leaves the other word untouched.
module clint_mtime #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lo_we,
    input  logic        hi_we,
    input  logic [31:0] wdata,
    output logic [63:0] mtime
);

    localparam logic [15:0] PRESC_LAST = 16'(TICK_DIV - 1);

    logic [15:0] presc;
    logic        tick;

    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc <= 16'd0;
            mtime <= 64'd0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (lo_we) begin
                mtime[31:0] <= wdata;
            end else if (hi_we) begin
                mtime[63:32] <= wdata;
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

endmodule

// File: rtl/clint_multihart.sv
// Multi-hart CLINT: shared mtime, per-hart mtimecmp/msip and registered irq lines.
// Latency: ack_o/data_o one cycle after req_i, irqs one cycle after the state they follow.
// Backpressure: none, a request may be issued every cycle and each gets one ack.
`ifndef CLINT_DEFINES_SV
`include "clint_defines.sv"
`endif

module clint_multihart
    import clint_multihart_pkg::*;
#(
    parameter int          NUM_HARTS     = 2,
    parameter int          TICK_DIV      = 1,
    parameter logic [15:0] MTIMECMP_BASE = `MTIMECMP_BASE,
    parameter logic [15:0] MSIP_BASE     = `MSIP_BASE,
    parameter logic [15:0] MTIME_BASE    = `MTIME_BASE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [`DATA_WIDTH-1:0] addr_i,
    input  logic [`DATA_WIDTH-1:0] data_i,
    output logic [`DATA_WIDTH-1:0] data_o,
    output logic                   ack_o,
    output logic [NUM_HARTS-1:0]   timer_irq_o,
    output logic [NUM_HARTS-1:0]   software_irq_o
);

    dec_t                   dec;
    logic                   wr;
    logic [63:0]            mtime;
    logic [63:0]            mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0]   msip;
    logic [`DATA_WIDTH-1:0] rdata;
    logic                   unused_addr_hi;

    assign unused_addr_hi = ^addr_i[`DATA_WIDTH-1:16];
    assign dec            = decode_addr(addr_i[15:0], MSIP_BASE, MTIMECMP_BASE, MTIME_BASE, NUM_HARTS);
    assign wr             = req_i & we_i;

    clint_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .lo_we (wr && dec.sel == REG_MTIME_LO),
        .hi_we (wr && dec.sel == REG_MTIME_HI),
        .wdata (data_i),
        .mtime (mtime)
    );

    for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
        logic hart_wr;
        assign hart_wr = wr && (dec.hart == 4'(h));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                mtimecmp[h]       <= '1;
                msip[h]           <= 1'b0;
                timer_irq_o[h]    <= 1'b0;
                software_irq_o[h] <= 1'b0;
            end else begin
                if (hart_wr && dec.sel == REG_CMP_LO) mtimecmp[h][31:0]  <= data_i;
                if (hart_wr && dec.sel == REG_CMP_HI) mtimecmp[h][63:32] <= data_i;
                if (hart_wr && dec.sel == REG_MSIP)   msip[h]            <= data_i[0];
                timer_irq_o[h]    <= (mtime >= mtimecmp[h]);
                software_irq_o[h] <= msip[h];
            end
        end
    end

    // Read data is taken from current register values, before this edge's updates.
    always_comb begin
        rdata = `ZERO;
        unique case (dec.sel)
            REG_MTIME_LO: rdata = mtime[31:0];
            REG_MTIME_HI: rdata = mtime[63:32];
            REG_CMP_LO, REG_CMP_HI, REG_MSIP: begin
                for (int h = 0; h < NUM_HARTS; h++) begin
                    if (dec.hart == 4'(h)) begin
                        if (dec.sel == REG_CMP_LO)      rdata = mtimecmp[h][31:0];
                        else if (dec.sel == REG_CMP_HI) rdata = mtimecmp[h][63:32];
                        else                            rdata = {31'b0, msip[h]};
                    end
                end
            end
            default: rdata = `ZERO;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o  <= 1'b0;
            data_o <= `ZERO;
        end else begin
            ack_o  <= req_i;
            data_o <= (req_i && !we_i) ? rdata : `ZERO;
        end
    end

endmodule
